ung_p_decoder: RTL and testbench

- Parallel unary-to-binary decoder. It is the receive end of the p-bit-per-cycle unary (thermometer) bit-stream produced by the parallel stream generator.
- Accepts p stream bits per cycle and accumulates the count of ones over a fixed-length frame. At frame end it presents the reconstructed width-bit binary value through a valid/ready handshake.
- Sits at the output of stochastic/unary compute lanes to convert results back to binary.

---
 rtl/ung_p_decoder.sv | 109 ++++++++++
 tb/tb_ung_p_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ung_p_decoder.sv
// Parallel unary-to-binary decoder: counts ones over a fixed frame of p-bit words and
// presents the saturated count via valid/ready. Define THERM_CHECK_EN for thermometer-order checking.
module ung_p_decoder #(
    parameter int width = 5,
    parameter int p     = 2,
    parameter int words = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [p-1:0]     un_data,
    input  logic             un_valid,
    output logic             un_ready,
    output logic [width-1:0] binary_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);
    localparam int CNT_W = (words > 1) ? $clog2(words) : 1;
    localparam int PC_W  = $clog2(p + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(words - 1);
    localparam logic [width:0]   MAX_VAL  = {1'b0, {width{1'b1}}};

    typedef enum logic {ACC, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] word_cnt;
    logic [width:0]   acc, acc_nxt;
    logic [PC_W-1:0]  pc;
    logic             xfer, last;

    always_comb begin
        pc = '0;
        for (int i = 0; i < p; i++) pc = pc + PC_W'(un_data[i]);
    end

    assign acc_nxt   = acc + (width + 1)'(pc);
    assign xfer      = (state == ACC) && un_valid;
    assign last      = xfer && (word_cnt == LAST_IDX);
    // Ready is forced low while reset is held, even though the reset state is ACC.
    assign un_ready  = rst && (state == ACC);
    assign out_valid = (state == HOLD);

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (last) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ACC;
            acc        <= '0;
            word_cnt   <= '0;
            binary_out <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                if (last) begin
                    acc        <= '0;
                    word_cnt   <= '0;
                    binary_out <= (acc_nxt > MAX_VAL) ? MAX_VAL[width-1:0] : acc_nxt[width-1:0];
                end else begin
                    acc      <= acc_nxt;
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

`ifdef THERM_CHECK_EN
    logic zero_seen, err_acc, err_q;
    logic z_nxt, e_nxt;

    // Scan in stream order: once a 0 has been seen, any later 1 breaks thermometer order.
    always_comb begin
        z_nxt = zero_seen;
        e_nxt = err_acc;
        for (int i = 0; i < p; i++) begin
            if (!un_data[i]) z_nxt = 1'b1;
            else if (z_nxt)  e_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_seen <= 1'b0;
            err_acc   <= 1'b0;
            err_q     <= 1'b0;
        end else if (xfer) begin
            if (last) begin
                zero_seen <= 1'b0;
                err_acc   <= 1'b0;
                err_q     <= e_nxt;
            end else begin
                zero_seen <= z_nxt;
                err_acc   <= e_nxt;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ung_p_decoder.sv
// Directed bench for ung_p_decoder: frame-level model of accepted stream bits plus
// literal expectations for each scenario.
module tb_ung_p_decoder;
    localparam int W     = 5;
    localparam int P     = 2;
    localparam int WORDS = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [P-1:0] un_data;
    logic         un_valid;
    logic         un_ready;
    logic [W-1:0] binary_out;
    logic         out_valid;
    logic         out_ready;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef THERM_CHECK_EN
    localparam bit THERM = 1'b1;
`else
    localparam bit THERM = 1'b0;
`endif

    ung_p_decoder #(.width(W), .p(P), .words(WORDS)) dut (
        .clk(clk), .rst(rst), .un_data(un_data), .un_valid(un_valid), .un_ready(un_ready),
        .binary_out(binary_out), .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: collect accepted bits in stream order, evaluate the whole frame at its end.
    bit bits_q[$];
    int model_val  = 0;
    bit model_err  = 0;
    bit model_hold = 0;
    bit acc_pulse  = 0;

    always @(posedge clk or negedge rst) begin
        acc_pulse = 0;
        if (!rst) begin
            bits_q.delete();
            model_hold = 0;
            model_val  = 0;
            model_err  = 0;
        end else if (!model_hold) begin
            if (un_valid) begin
                acc_pulse = 1;
                for (int i = 0; i < P; i++) bits_q.push_back(un_data[i]);
                if (bits_q.size() == WORDS * P) begin
                    int  ones;
                    bit  zero;
                    ones = 0;
                    zero = 0;
                    model_err = 0;
                    foreach (bits_q[k]) begin
                        if (bits_q[k]) begin
                            ones++;
                            if (zero) model_err = THERM;
                        end else zero = 1;
                    end
                    model_val  = (ones > (1 << W) - 1) ? (1 << W) - 1 : ones;
                    model_hold = 1;
                    bits_q.delete();
                end
            end
        end else if (out_ready) model_hold = 0;
    end

    always @(negedge clk) begin
        check("un_ready", un_ready, (rst && !model_hold) ? 1 : 0);
        check("out_valid", out_valid, model_hold);
        check("binary_out", binary_out, model_val);
        if (model_hold) check("err", err, model_err);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [P-1:0] w, input bit gaps);
        int n;
        if (gaps) begin
            un_valid = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
        end
        un_data  = w;
        un_valid = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!acc_pulse && n < 50);
        if (!acc_pulse) check("accept_timeout", 0, 1);
    endtask

    task automatic send_rep(input logic [P-1:0] w, input int cnt, input bit gaps);
        for (int i = 0; i < cnt; i++) send_word(w, gaps);
    endtask

    task automatic expect_result(input string name, input int val, input int e);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            cyc();
            n++;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_value"}, binary_out, val);
        check({name, "_err"}, err, e);
    endtask

    initial begin
        rst = 1'b0; un_data = '0; un_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("reset_un_ready", un_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_binary_out", binary_out, 0);
        check("reset_err", err, 0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();

        // value 5, un_valid held high; out_valid already up right after the final transfer
        send_word(2'b11, 0); send_word(2'b11, 0); send_word(2'b01, 0);
        send_rep(2'b00, 13, 0);
        check("v5_latency", out_valid, 1);
        expect_result("v5", 5, 0);

        send_rep(2'b11, 16, 0);
        expect_result("sat31", 31, 0);

        send_rep(2'b00, 16, 0);
        expect_result("zero", 0, 0);

        // backpressure: value 2 frame, consumer stalls 10 cycles
        send_word(2'b11, 0);
        send_rep(2'b00, 14, 0);
        out_ready = 1'b0;
        send_word(2'b00, 0);
        un_data = 2'b11;
        for (int i = 0; i < 10; i++) begin
            check("stall_un_ready", un_ready, 0);
            check("stall_binary_out", binary_out, 2);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        check("release_un_ready", un_ready, 1);
        check("release_binary_out", binary_out, 2);

        // value 17 with random gaps
        send_rep(2'b11, 8, 1); send_word(2'b01, 1); send_rep(2'b00, 7, 1);
        un_valid = 1'b0;
        expect_result("v17_gaps", 17, 0);

        // thermometer violation 01,01
        send_word(2'b01, 0); send_word(2'b01, 0); send_rep(2'b00, 14, 0);
        expect_result("therm", 2, THERM ? 1 : 0);

        // single word 2'b10 is out of order too
        send_word(2'b10, 0); send_rep(2'b00, 15, 0);
        expect_result("therm10", 1, THERM ? 1 : 0);

        // reset during word 7, then clean value 3
        send_rep(2'b11, 7, 0);
        un_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_un_ready", un_ready, 0);
        check("midrst_binary_out", binary_out, 0);
        cyc();
        rst = 1'b1;
        cyc();
        send_word(2'b11, 0); send_word(2'b01, 0); send_rep(2'b00, 14, 0);
        un_valid = 1'b0;
        expect_result("after_rst", 3, 0);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
